// File: rtl/rs232_avm_slave.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rs232_avm_slave
//
// Avalon-MM slave wrapping an 8N1 UART (LSB first, idle-high line).
// Register map (byte addresses):
//   0x00  RX data  (read)  : {24'b0, rx_byte}, pops the RX holding register
//   0x04  TX data  (write) : writedata[7:0] is transmitted when TRDY=1
//   0x08  status   (read)  : bit7 RRDY, bit6 TRDY, bit3 ROE, bit2 FE
//
// Every transfer takes exactly two cycles: one wait state, then completion.
//
// Ports:
//   avm_clk          single clock for all logic
//   avm_rst          asynchronous active-high reset
//   avs_address      5-bit byte address
//   avs_read/write   Avalon-MM requests
//   avs_writedata    write data, only [7:0] used
//   avs_readdata     read response, valid in the completion cycle
//   avs_waitrequest  stall, high in the first cycle of each transfer
//   uart_rxd         serial input (asynchronous, synchronized internally)
//   uart_txd         serial output
//
// Parameter:
//   CLKS_PER_BIT     clock cycles per serial bit, >= 4
//
// Configuration macro:
//   RS232_RX_FIFO_EN when defined, the RX holding register becomes a
//                    4-entry FIFO; otherwise a single holding register.
// -----------------------------------------------------------------------------
module rs232_avm_slave #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  localparam logic [4:0] ADDR_RX   = 5'd0;
  localparam logic [4:0] ADDR_TX   = 5'd4;
  localparam logic [4:0] ADDR_STAT = 5'd8;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  // ---------------------------------------------------------------------------
  // Bus handshake
  // ---------------------------------------------------------------------------
  logic        req;
  logic        ack_reg;
  logic        xfer_done;
  logic [31:0] readdata_reg;
  logic [31:0] rdata_next;
  logic        rd_armed_reg;
  logic        rd_armed_next;
  logic        rx_rd_done;
  logic        tx_wr_done;

  // Shared status / RX holding signals
  logic        rrdy;
  logic        trdy;
  logic [7:0]  rx_head;
  logic        roe_reg;
  logic        fe_reg;
  logic        rx_pop;
  logic        overrun;
  logic [7:0]  status;

  // Upper write data bits are intentionally ignored.
  logic        unused_wdata;
  assign unused_wdata = ^avs_writedata[31:8];

  assign req             = avs_read | avs_write;
  assign avs_waitrequest = req & ~ack_reg;
  assign xfer_done       = req & ack_reg;
  assign avs_readdata    = readdata_reg;

  assign rx_rd_done = xfer_done & avs_read & (avs_address == ADDR_RX);
  assign tx_wr_done = xfer_done & avs_write & ~avs_read & (avs_address == ADDR_TX);

  assign status = {rrdy, trdy, 2'b00, roe_reg, fe_reg, 2'b00};

  // Read data is captured during the wait cycle and presented in the
  // completion cycle. The pop is armed only if the captured data was real,
  // so a byte landing between the two cycles is never lost.
  always_comb begin
    rdata_next    = 32'd0;
    rd_armed_next = 1'b0;
    if (avs_read && !ack_reg) begin
      case (avs_address)
        ADDR_RX: begin
          rdata_next    = rrdy ? {24'd0, rx_head} : 32'd0;
          rd_armed_next = rrdy;
        end
        ADDR_STAT: rdata_next = {24'd0, status};
        default:   rdata_next = 32'd0;
      endcase
    end
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      ack_reg      <= 1'b0;
      readdata_reg <= 32'd0;
      rd_armed_reg <= 1'b0;
    end else begin
      ack_reg      <= req & ~ack_reg;
      readdata_reg <= rdata_next;
      rd_armed_reg <= rd_armed_next;
    end
  end

  assign rx_pop = rx_rd_done & rd_armed_reg;

  // ---------------------------------------------------------------------------
  // RX synchronizer and edge detect
  // ---------------------------------------------------------------------------
  logic [1:0] sync_reg;
  logic       rx_s;
  logic       rx_prev_reg;

  assign rx_s = sync_reg[1];

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], uart_rxd};
      rx_prev_reg <= rx_s;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  rx_state_t      rx_state_reg, rx_state_next;
  logic [BW-1:0]  rx_baud_reg, rx_baud_next;
  logic [2:0]     rx_bit_reg, rx_bit_next;
  logic [7:0]     rx_shift_reg, rx_shift_next;
  logic           rx_ok;
  logic           rx_err;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rx_state_reg <= R_IDLE;
      rx_baud_reg  <= '0;
      rx_bit_reg   <= 3'd0;
      rx_shift_reg <= 8'd0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_baud_reg  <= rx_baud_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_baud_next  = rx_baud_reg + BAUD_ONE;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_ok         = 1'b0;
    rx_err        = 1'b0;
    case (rx_state_reg)
      R_IDLE: begin
        rx_baud_next = '0;
        if (rx_prev_reg && !rx_s) rx_state_next = R_START;
      end
      R_START: begin
        // Mid-point of the start bit: a line already back high was a glitch.
        if (rx_baud_reg == BAUD_HALF) begin
          rx_baud_next  = '0;
          rx_bit_next   = 3'd0;
          rx_state_next = rx_s ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_baud_reg == BAUD_LAST) begin
          rx_baud_next  = '0;
          rx_shift_next = {rx_s, rx_shift_reg[7:1]};
          rx_bit_next   = rx_bit_reg + 3'd1;
          if (rx_bit_reg == 3'd7) rx_state_next = R_STOP;
        end
      end
      R_STOP: begin
        if (rx_baud_reg == BAUD_LAST) begin
          rx_baud_next  = '0;
          rx_state_next = R_IDLE;
          rx_ok         = rx_s;
          rx_err        = ~rx_s;
        end
      end
      default: rx_state_next = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX holding storage
  // ---------------------------------------------------------------------------
`ifdef RS232_RX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr_reg;
  logic [1:0] rd_ptr_reg;
  logic [2:0] count_reg;
  logic       fifo_full;
  logic       fifo_push;

  assign fifo_full = (count_reg == 3'd4);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign fifo_push = rx_ok & (~fifo_full | rx_pop);
  assign overrun   = rx_ok & fifo_full & ~rx_pop;
  assign rrdy      = (count_reg != 3'd0);
  assign rx_head   = fifo_mem[rd_ptr_reg];

  always_ff @(posedge avm_clk) begin
    if (fifo_push) fifo_mem[wr_ptr_reg] <= rx_shift_reg;
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (rx_pop)    rd_ptr_reg <= rd_ptr_reg + 2'd1;
      case ({fifo_push, rx_pop})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end
`else
  logic [7:0] rx_byte_reg;
  logic       rrdy_reg;

  // A byte arriving while the old one is being read replaces it cleanly.
  assign overrun = rx_ok & rrdy_reg & ~rx_pop;
  assign rrdy    = rrdy_reg;
  assign rx_head = rx_byte_reg;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rx_byte_reg <= 8'd0;
      rrdy_reg    <= 1'b0;
    end else if (rx_ok && !overrun) begin
      rx_byte_reg <= rx_shift_reg;
      rrdy_reg    <= 1'b1;
    end else if (rx_pop) begin
      rrdy_reg    <= 1'b0;
    end
  end
`endif

  // Error flags: a new event in the clearing cycle wins over the clear.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      roe_reg <= 1'b0;
      fe_reg  <= 1'b0;
    end else begin
      if (overrun)         roe_reg <= 1'b1;
      else if (rx_rd_done) roe_reg <= 1'b0;
      if (rx_err)          fe_reg  <= 1'b1;
      else if (rx_rd_done) fe_reg  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  tx_state_t      tx_state_reg, tx_state_next;
  logic [BW-1:0]  tx_baud_reg, tx_baud_next;
  logic [2:0]     tx_bit_reg, tx_bit_next;
  logic [7:0]     tx_shift_reg, tx_shift_next;
  logic           txd_reg, txd_next;
  logic           tx_load;

  // The transmitter is free exactly when it sits idle.
  assign trdy     = (tx_state_reg == T_IDLE);
  assign tx_load  = tx_wr_done & trdy;
  assign uart_txd = txd_reg;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      tx_state_reg <= T_IDLE;
      tx_baud_reg  <= '0;
      tx_bit_reg   <= 3'd0;
      tx_shift_reg <= 8'd0;
      txd_reg      <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_baud_reg  <= tx_baud_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      txd_reg      <= txd_next;
    end
  end

  // The line value is computed one cycle ahead so uart_txd is a flop output.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_baud_next  = tx_baud_reg + BAUD_ONE;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    txd_next      = txd_reg;
    case (tx_state_reg)
      T_IDLE: begin
        tx_baud_next = '0;
        txd_next     = 1'b1;
        if (tx_load) begin
          tx_state_next = T_START;
          tx_shift_next = avs_writedata[7:0];
          txd_next      = 1'b0;
        end
      end
      T_START: begin
        if (tx_baud_reg == BAUD_LAST) begin
          tx_baud_next  = '0;
          tx_bit_next   = 3'd0;
          tx_state_next = T_DATA;
          txd_next      = tx_shift_reg[0];
        end
      end
      T_DATA: begin
        if (tx_baud_reg == BAUD_LAST) begin
          tx_baud_next = '0;
          tx_bit_next  = tx_bit_reg + 3'd1;
          if (tx_bit_reg == 3'd7) begin
            tx_state_next = T_STOP;
            txd_next      = 1'b1;
          end else begin
            tx_shift_next = {1'b0, tx_shift_reg[7:1]};
            txd_next      = tx_shift_reg[1];
          end
        end
      end
      T_STOP: begin
        if (tx_baud_reg == BAUD_LAST) begin
          tx_baud_next  = '0;
          tx_state_next = T_IDLE;
        end
      end
      default: tx_state_next = T_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rs232_avm_slave.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_rs232_avm_slave
//
// Directed bench for rs232_avm_slave with CLKS_PER_BIT=4. Bus reads push their
// expected data into rd_q; a monitor compares avs_readdata in each completion
// cycle. TX writes push the expected byte into tx_q; a line monitor checks
// every cycle of each transmitted frame against it.
// -----------------------------------------------------------------------------
module tb_rs232_avm_slave;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic        uart_rxd;
  logic        uart_txd;

  always #5 clk = ~clk;

  rs232_avm_slave #(.CLKS_PER_BIT(CPB)) dut (
    .avm_clk         (clk),
    .avm_rst         (rst),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .uart_rxd        (uart_rxd),
    .uart_txd        (uart_txd)
  );

  typedef struct {
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t       rd_q[$];
  logic [7:0] tx_q[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Read-data monitor
  // ---------------------------------------------------------------------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && avs_read && !avs_waitrequest) begin
      if (rd_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rd_unexpected: got 0x%08h, expected no completion", avs_readdata);
      end else begin
        mon_e = rd_q.pop_front();
        check(mon_e.name, avs_readdata, mon_e.data);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX line monitor: every cycle of the frame is compared
  // ---------------------------------------------------------------------------
  logic       tx_prev = 1'b1;
  bit         tx_act  = 1'b0;
  bit         tx_bad;
  int         tx_cnt;
  logic [9:0] tx_bits;
  logic [7:0] tx_exp;

  always @(negedge clk) begin
    if (rst) begin
      if (tx_act) $display("note tx frame 0x%02h aborted by reset", tx_exp);
      tx_act = 1'b0;
    end else if (!tx_act && tx_prev === 1'b1 && uart_txd === 1'b0) begin
      if (tx_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL tx_unexpected: got start bit, expected idle line");
      end else begin
        tx_exp  = tx_q.pop_front();
        tx_bits = {1'b1, tx_exp, 1'b0};
        tx_act  = 1'b1;
        tx_cnt  = 0;
        tx_bad  = 1'b0;
      end
    end
    if (!rst && tx_act) begin
      if (uart_txd !== tx_bits[tx_cnt / CPB]) tx_bad = 1'b1;
      tx_cnt++;
      if (tx_cnt == 10 * CPB) begin
        vectors++;
        if (tx_bad) begin
          miscompares++;
          $display("FAIL tx_frame: got wrong line waveform, expected byte 0x%02h", tx_exp);
        end else begin
          $display("ok   tx_frame: 0x%02h", tx_exp);
        end
        tx_act = 1'b0;
      end
    end
    tx_prev = uart_txd;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (each starts and ends 1 ns after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int wait_cyc;
    wait_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      wait_cyc++;
    end
    check({name, "_wait"}, wait_cyc, 32'd1);
  endtask

  task automatic bus_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
    exp_t e;
    e.data = exp;
    e.name = name;
    rd_q.push_back(e);
    avs_address = addr;
    avs_read    = 1'b1;
    wait_done(name);
    @(posedge clk);
    #1;
    avs_read = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [7:0] data, input string name);
    avs_address   = addr;
    avs_writedata = {24'hABCDEF, data};
    avs_write     = 1'b1;
    wait_done(name);
    @(posedge clk);
    #1;
    avs_write = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    uart_rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = data[i];
      idle(CPB);
    end
    uart_rxd = stop_bit;
    idle(CPB);
    uart_rxd = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst           = 1'b1;
    avs_address   = 5'd0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = 32'd0;
    uart_rxd      = 1'b1;
    idle(3);
    check("rst_txd", {31'd0, uart_txd}, 32'd1);
    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_waitreq_idle", {31'd0, avs_waitrequest}, 32'd0);
    avs_read = 1'b1;
    #1;
    check("rst_waitreq_req", {31'd0, avs_waitrequest}, 32'd1);
    avs_read = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(2);

    // Status after reset
    bus_read(5'd8, 32'h40, "stat_reset");

    // Receive 0xA5
    send_frame(8'hA5, 1'b1);
    idle(4);
    bus_read(5'd8, 32'hC0, "stat_rx_a5");
    bus_read(5'd0, 32'hA5, "rd_a5");
    bus_read(5'd8, 32'h40, "stat_after_rd");

    // Empty read, unmapped and no-effect accesses
    bus_read(5'd0, 32'h00, "rd_empty");
    bus_read(5'd4, 32'h00, "rd_addr4");
    bus_read(5'd12, 32'h00, "rd_addr12");
    bus_write(5'd0, 8'hFF, "wr_addr0");
    bus_write(5'd8, 8'hFF, "wr_addr8");
    bus_write(5'd20, 8'hFF, "wr_addr20");
    bus_read(5'd8, 32'h40, "stat_no_effect");
    idle(50);

    // Transmit 0x3C; second write during the frame is dropped
    tx_q.push_back(8'h3C);
    bus_write(5'd4, 8'h3C, "wr_tx_3c");          // completion cycle c
    bus_read(5'd8, 32'h00, "stat_tx_busy");      // sampled at c+1
    bus_write(5'd4, 8'h99, "wr_tx_dropped");     // during frame
    idle(35);
    bus_read(5'd8, 32'h00, "stat_last_stop");    // sampled at c+40
    bus_read(5'd8, 32'h40, "stat_tx_idle");
    idle(60);

    // Two frames without a read
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(4);
`ifdef RS232_RX_FIFO_EN
    bus_read(5'd8, 32'hC0, "stat_two_frames");
    bus_read(5'd0, 32'h11, "rd_first");
    bus_read(5'd0, 32'h22, "rd_second");
    bus_read(5'd8, 32'h40, "stat_drained");
`else
    bus_read(5'd8, 32'hC8, "stat_overrun");
    bus_read(5'd0, 32'h11, "rd_kept_old");
    bus_read(5'd8, 32'h40, "stat_roe_cleared");
    bus_read(5'd0, 32'h00, "rd_new_dropped");
`endif

    // Framing error
    send_frame(8'h55, 1'b0);
    idle(4);
    bus_read(5'd8, 32'h44, "stat_fe");
    bus_read(5'd0, 32'h00, "rd_fe_nodata");
    bus_read(5'd8, 32'h40, "stat_fe_cleared");

    // One-cycle glitch
    uart_rxd = 1'b0;
    idle(1);
    uart_rxd = 1'b1;
    idle(20);
    bus_read(5'd8, 32'h40, "stat_glitch");

    // RX capture in the same cycle as an RX read completion
    send_frame(8'h66, 1'b1);
    idle(4);
    fork
      send_frame(8'h77, 1'b1);                   // starts in cycle k
      begin
        idle(39);
        bus_read(5'd0, 32'h66, "rd_collide");    // completes in k+40
      end
    join
    idle(4);
    bus_read(5'd8, 32'hC0, "stat_collide");
    bus_read(5'd0, 32'h77, "rd_after_collide");
    bus_read(5'd8, 32'h40, "stat_collide_done");

    // Reset in the middle of a TX frame
    tx_q.push_back(8'hF0);
    bus_write(5'd4, 8'hF0, "wr_tx_f0");
    idle(10);
    rst = 1'b1;
    #1;
    check("midrst_txd", {31'd0, uart_txd}, 32'd1);
    check("midrst_waitreq", {31'd0, avs_waitrequest}, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(1);
    bus_read(5'd8, 32'h40, "stat_after_midrst");
    tx_q.push_back(8'h81);
    bus_write(5'd4, 8'h81, "wr_tx_81");          // completion cycle c
    bus_read(5'd8, 32'h00, "stat_tx81_busy");
    idle(38);
    bus_read(5'd8, 32'h40, "stat_trdy_back");    // sampled at c+41
    idle(20);

    check("rd_queue_empty", rd_q.size(), 32'd0);
    check("tx_queue_empty", tx_q.size(), 32'd0);
    check("tx_monitor_idle", {31'd0, tx_act}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
